// File: rtl/types_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit.
package types_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = $clog2(XLEN);

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFixup,
    StDone
  } muldiv_state_e;

  typedef enum logic [2:0] {
    OpMul    = 3'b000,
    OpMulh   = 3'b001,
    OpMulhsu = 3'b010,
    OpMulhu  = 3'b011,
    OpDiv    = 3'b100,
    OpDivu   = 3'b101,
    OpRem    = 3'b110,
    OpRemu   = 3'b111
  } muldiv_op_e;

  function automatic logic op_is_div(input muldiv_op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Operand magnitudes, shift-add / restoring-divide accumulator, sign fixup and result register.
module muldiv_datapath
  import types_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            step,
  input  logic            fixup,
  input  logic            short_load,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            shortcut,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_op_e          op_q, op_d, op_in;
  logic                neg_q, neg_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     result_q, result_d;

  logic                s1, s2, div_zero, div_ovf, neg_in;
  logic [XLEN-1:0]     a_mag, b_mag, short_val, fix_val;
  logic [XLEN-1:0]     hi, lo;
  logic [XLEN:0]       mul_sum, div_shift, div_sub;
  logic [2*XLEN-1:0]   prod_fix;
  logic                unused_div_msb;

  assign hi             = acc_q[2*XLEN-1:XLEN];
  assign lo             = acc_q[XLEN-1:0];
  assign mul_sum        = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : '0);
  assign div_shift      = {hi, lo[XLEN-1]};
  assign div_sub        = div_shift - {1'b0, b_q};
  // A successful trial leaves a remainder below the divisor, so the top bit is always clear.
  assign unused_div_msb = div_sub[XLEN];

  always_comb begin
    op_in    = muldiv_op_e'(funct3);
    s1       = rs1[XLEN-1] & (op_in inside {OpMulh, OpMulhsu, OpDiv, OpRem});
    s2       = rs2[XLEN-1] & (op_in inside {OpMulh, OpDiv, OpRem});
    a_mag    = s1 ? ('0 - rs1) : rs1;
    b_mag    = s2 ? ('0 - rs2) : rs2;
    neg_in   = (op_is_div(op_in) && funct3[1]) ? s1 : (s1 ^ s2);
    div_zero = op_is_div(op_in) && (rs2 == '0);
    div_ovf  = (op_in inside {OpDiv, OpRem}) && (rs1 == MinNeg) && (rs2 == '1);
    shortcut = div_zero || div_ovf;
    if (div_zero) begin
      short_val = funct3[1] ? rs1 : '1;
    end else begin
      short_val = funct3[1] ? '0 : MinNeg;
    end
  end

  always_comb begin
    prod_fix = neg_q ? ('0 - acc_q) : acc_q;
    unique case (op_q)
      OpMul:                     fix_val = prod_fix[XLEN-1:0];
      OpMulh, OpMulhsu, OpMulhu: fix_val = prod_fix[2*XLEN-1:XLEN];
      OpDiv, OpDivu:             fix_val = neg_q ? ('0 - lo) : lo;
      OpRem, OpRemu:             fix_val = neg_q ? ('0 - hi) : hi;
      default:                   fix_val = '0;
    endcase
  end

  always_comb begin
    op_d     = op_q;
    neg_d    = neg_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    if (load) begin
      op_d  = op_in;
      neg_d = neg_in;
      if (op_is_div(op_in)) begin
        b_d   = b_mag;
        acc_d = {{XLEN{1'b0}}, a_mag};
      end else begin
        b_d   = a_mag;
        acc_d = {{XLEN{1'b0}}, b_mag};
      end
    end else if (step) begin
      if (op_is_div(op_q)) begin
        if (div_shift >= {1'b0, b_q}) begin
          acc_d = {div_sub[XLEN-1:0], lo[XLEN-2:0], 1'b1};
        end else begin
          acc_d = {div_shift[XLEN-1:0], lo[XLEN-2:0], 1'b0};
        end
      end else begin
        acc_d = {mul_sum, lo[XLEN-1:1]};
      end
    end
    if (short_load) begin
      result_d = short_val;
    end else if (fixup) begin
      result_d = fix_val;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q     <= OpMul;
      neg_q    <= 1'b0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      op_q     <= op_d;
      neg_q    <= neg_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer: FSM, iteration counter and pipeline stall.
module muldiv_sequencer
  import types_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  muldiv_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept, shortcut;

  assign accept = (state_q == StIdle) && start && !flush;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = shortcut ? StDone : StCalc;
          cnt_d   = CNT_W'(XLEN - 1);
        end
      end
      StCalc: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = StFixup;
        end
      end
      StFixup: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (flush) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == StCalc) || (state_q == StFixup);
  assign done = (state_q == StDone);
  // A start held through reset must not stall the pipeline until reset is released.
  assign stall = !reset && (accept || busy);

  muldiv_datapath #(
    .XLEN(XLEN)
  ) u_datapath (
    .clk        (clk),
    .reset      (reset),
    .load       (accept && !shortcut),
    .step       ((state_q == StCalc) && !flush),
    .fixup      ((state_q == StFixup) && !flush),
    .short_load (accept && shortcut),
    .funct3     (funct3),
    .rs1        (rs1),
    .rs2        (rs2),
    .shortcut   (shortcut),
    .result     (result)
  );

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer against an arithmetic reference model.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2;
  logic        busy, stall, done;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] last_result = '0;

  localparam logic [31:0] MinNeg = 32'h8000_0000;

  typedef struct packed {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  always #5 clk = ~clk;

  muldiv_sequencer dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .funct3 (funct3),
    .rs1    (rs1),
    .rs2    (rs2),
    .flush  (flush),
    .busy   (busy),
    .stall  (stall),
    .done   (done),
    .result (result)
  );

  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p;
    int          ia, ib;
    logic        ovf;
    logic [31:0] r;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ia  = a;
    ib  = b;
    ovf = (a == MinNeg) && (b == 32'hFFFF_FFFF);
    p   = '0;
    r   = '0;
    case (f3)
      3'd0: begin p = {32'b0, a} * {32'b0, b};     r = p[31:0];  end
      3'd1: begin p = sa * sb;                       r = p[63:32]; end
      3'd2: begin p = sa * longint'({32'b0, b});     r = p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b};     r = p[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? MinNeg : 32'(ia / ib);
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: r = (b == 0) ? a : ovf ? 32'd0 : 32'(ia % ib);
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Called at the start of a cycle (just after a rising edge) with the unit idle.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string name);
    logic sc;
    int   lat;
    sc  = f3[2] && ((b == 0) || (!f3[0] && a == MinNeg && b == 32'hFFFF_FFFF));
    lat = sc ? 1 : 34;
    funct3 = f3; rs1 = a; rs2 = b; start = 1'b1;
    for (int c = 0; c <= lat + 1; c++) begin
      if (c == lat + 1) start = 1'b0;
      @(negedge clk);
      n_checks += 3;
      if (stall !== (c < lat)) begin
        n_fail++;
        $display("FAIL %s stall cycle %0d got %b want %b", name, c, stall, c < lat);
      end
      if (done !== (c == lat)) begin
        n_fail++;
        $display("FAIL %s done cycle %0d got %b want %b", name, c, done, c == lat);
      end
      if (busy !== (!sc && c >= 1 && c < lat)) begin
        n_fail++;
        $display("FAIL %s busy cycle %0d got %b want %b", name, c, busy,
                 !sc && c >= 1 && c < lat);
      end
      if (c >= lat) begin
        n_checks++;
        if (result !== exp) begin
          n_fail++;
          $display("FAIL %s result cycle %0d got %h want %h", name, c, result, exp);
        end
      end
      @(posedge clk); #1;
    end
    last_result = exp;
  endtask

  task automatic test_reset();
    n_checks += 4;
    if (busy !== 1'b0)   begin n_fail++; $display("FAIL reset busy got %b want 0", busy);   end
    if (done !== 1'b0)   begin n_fail++; $display("FAIL reset done got %b want 0", done);   end
    if (stall !== 1'b0)  begin n_fail++; $display("FAIL reset stall got %b want 0", stall); end
    if (result !== '0)   begin n_fail++; $display("FAIL reset result got %h want 0", result); end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    vec_t v[13];
    v[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
    v[1]  = '{3'd1, MinNeg,         MinNeg,        32'h4000_0000};
    v[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    v[3]  = '{3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF};
    v[4]  = '{3'd5, 32'd100,        32'd7,         32'd14};
    v[5]  = '{3'd7, 32'd100,        32'd7,         32'd2};
    v[6]  = '{3'd4, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2};
    v[7]  = '{3'd6, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE};
    v[8]  = '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF};
    v[9]  = '{3'd7, 32'd5,          32'd0,         32'd5};
    v[10] = '{3'd4, MinNeg,         32'hFFFF_FFFF, MinNeg};
    v[11] = '{3'd6, MinNeg,         32'hFFFF_FFFF, 32'd0};
    v[12] = '{3'd1, 32'd3,          32'hFFFF_FFFF, 32'hFFFF_FFFF};
    for (int i = 0; i < 13; i++) begin
      run_op(v[i].f3, v[i].a, v[i].b, v[i].exp, $sformatf("directed%0d", i));
    end
  endtask

  task automatic test_flush();
    funct3 = 3'd0; rs1 = $urandom; rs2 = $urandom; start = 1'b1;
    for (int c = 0; c <= 11; c++) begin
      if (c == 10) flush = 1'b1;
      if (c == 11) begin flush = 1'b0; start = 1'b0; end
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0) begin
        n_fail++; $display("FAIL flush done cycle %0d got %b want 0", c, done);
      end
      if (c == 11) begin
        n_checks += 3;
        if (busy !== 1'b0)  begin n_fail++; $display("FAIL flush busy got %b want 0", busy); end
        if (stall !== 1'b0) begin n_fail++; $display("FAIL flush stall got %b want 0", stall); end
        if (result !== last_result) begin
          n_fail++; $display("FAIL flush result got %h want %h", result, last_result);
        end
      end
      @(posedge clk); #1;
    end
    run_op(3'd0, 32'd123, 32'd456, 32'd56088, "after_flush");
  endtask

  task automatic test_flush_idle();
    funct3 = 3'd5; rs1 = 32'd9; rs2 = 32'd0; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_idle stall got %b want 0", stall); end
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    n_checks += 3;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_idle busy got %b want 0", busy); end
    if (done !== 1'b0) begin n_fail++; $display("FAIL flush_idle done got %b want 0", done); end
    if (result !== last_result) begin
      n_fail++; $display("FAIL flush_idle result got %h want %h", result, last_result);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [2:0]  f3;
    logic [31:0] ops[2];
    for (int i = 0; i < 24; i++) begin
      f3 = 3'($urandom_range(0, 7));
      for (int k = 0; k < 2; k++) begin
        case ($urandom_range(0, 7))
          0:       ops[k] = 32'd0;
          1:       ops[k] = 32'hFFFF_FFFF;
          2:       ops[k] = MinNeg;
          3:       ops[k] = 32'($urandom_range(1, 20));
          default: ops[k] = $urandom;
        endcase
      end
      run_op(f3, ops[0], ops[1], ref_result(f3, ops[0], ops[1]), $sformatf("random%0d", i));
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a, b, exp;
    a = $urandom; b = $urandom; exp = ref_result(3'd3, a, b);
    funct3 = 3'd3; rs1 = a; rs2 = b; start = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #1;
    n_checks += 4;
    if (busy !== 1'b0)  begin n_fail++; $display("FAIL rst_mid busy got %b want 0", busy);   end
    if (done !== 1'b0)  begin n_fail++; $display("FAIL rst_mid done got %b want 0", done);   end
    if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_mid stall got %b want 0", stall); end
    if (result !== '0)  begin n_fail++; $display("FAIL rst_mid result got %h want 0", result); end
    last_result = '0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL rst_mid held stall got %b want 1", stall); end
    for (int c = 1; c <= 34; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      n_checks += 2;
      if (done !== (c == 34)) begin
        n_fail++; $display("FAIL rst_mid done cycle %0d got %b want %b", c, done, c == 34);
      end
      if (busy !== (c <= 33)) begin
        n_fail++; $display("FAIL rst_mid busy cycle %0d got %b want %b", c, busy, c <= 33);
      end
      if (c == 34) begin
        n_checks++;
        if (result !== exp) begin
          n_fail++; $display("FAIL rst_mid result got %h want %h", result, exp);
        end
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
    last_result = exp;
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; rs1 = '0; rs2 = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_directed();
    test_flush();
    test_flush_idle();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative RV32M multiply/divide unit with FSM sequencing, placed in the EX stage beside the ALU.
- Accepts one M-extension operation from the controller, runs a 32-step shift-add multiply or restoring divide, and stalls the pipeline until the result is ready.
- Presents the result for exactly one cycle. Supports kill by pipeline flush.

Parameters:
- XLEN, 32, operand/result width
- CNT_W, $clog2(XLEN), iteration counter width

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  M-op valid in EX (decoded opcode OP with funct7 MULDIV)
- funct3  input  3  funct3_e M encoding: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
- rs1  input  XLEN  operand A (multiplicand/dividend)
- rs2  input  XLEN  operand B (multiplier/divisor)
- flush  input  1  kill in-flight op (branch/exception flush of EX)
- busy  output  1  state is CALC or FIXUP
- stall  output  1  freeze IF/ID/EX registers (combinational)
- done  output  1  result valid, one cycle
- result  output  XLEN  RV32M result

Behaviour:
- Reset (async): state=IDLE, busy=0, done=0, result=0, counter=0, internal registers=0.
- States: IDLE, CALC, FIXUP, DONE.
- IDLE, start=1, flush=0:
  - Latch funct3 and operands.
  - Form magnitudes |rs1|, |rs2| per signedness: MULH and DIV/REM signed both; MULHSU signed rs1 only; MUL sign-agnostic (low word).
  - Record neg_res: s1^s2 for product and quotient; s1 for remainder.
  - counter=XLEN-1; go to CALC.
- Divide shortcuts (IDLE goes directly to DONE; no CALC/FIXUP):
  - rs2==0: quotient=all-ones, remainder=rs1.
  - Signed overflow (DIV/REM, rs1=0x80000000, rs2=-1): quotient=0x80000000, remainder=0.
- CALC, one iteration per cycle:
  - Multiply: 2*XLEN product accumulator; add multiplicand if multiplier LSB=1, then shift.
  - Divide: restoring; shift remainder:dividend left, trial-subtract divisor, set quotient bit if non-negative.
  - counter decrements; counter==0 in CALC goes to FIXUP after that iteration (XLEN cycles in CALC).
- FIXUP: negate product/quotient/remainder if neg_res; select output word (MUL low, MULH* high, DIV*/REM* quotient/remainder); register result; go to DONE.
- DONE: done=1 for one cycle; result stable; go to IDLE next cycle. result holds its value after DONE until the next FIXUP or shortcut.
- Latency, start sampled at cycle 0:
  - Normal: CALC cycles 1..32, FIXUP cycle 33, done=1 in cycle 34.
  - Shortcut: done=1 in cycle 1.
- stall = (state==IDLE & start & ~flush) | (state==CALC) | (state==FIXUP). stall=0 in DONE, so EX advances and captures result.
- start while not IDLE: ignored. The pipeline is stalled, so start stays asserted, and a new op is not re-accepted in DONE.
- flush, any state: next state IDLE; no done for the killed op; result unchanged. flush together with start in IDLE: flush wins, nothing accepted.
- reset mid-operation: immediate IDLE, all outputs to reset values.
- Arithmetic is modulo 2^XLEN. Negation is two's complement. Magnitude of 0x80000000 is 0x80000000 interpreted unsigned.

Decomposition:
- types_pkg:
  - muldiv_state_e (IDLE, CALC, FIXUP, DONE)
  - muldiv_op_e, M-extension funct3 encodings, or reuse of funct3_e M values
  - FUNCT7_MULDIV constant
- Controller is extended to drive start from the decode of funct7 MULDIV.
- One sub-module, muldiv_datapath: accumulator, shift/trial-subtract, and negate logic, steered by state and counter. The FSM and counter stay in muldiv_sequencer.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD -> stall 1 in cycles 0..33, done in cycle 34 only, result=0xFFFFFFEB.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIVU 100/7 -> 14. REMU 100/7 -> 2. DIV -100/7 -> 0xFFFFFFF2 (-14). REM -100/7 -> 0xFFFFFFFE (-2).
- DIV 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5, DIV 0x80000000/-1 -> 0x80000000, each with done in cycle 1 and stall only in cycle 0.
- Start MUL, assert flush in cycle 10 -> IDLE and busy=0 in cycle 11, no done pulse, result unchanged; a new start in cycle 12 completes normally in cycle 46.
- Assert reset mid-CALC (cycle 5) -> busy, done, stall, and result all 0 immediately; held start is accepted on the first edge after reset deasserts.
